// File: rtl/count_checker.sv
// Monitors a 4-bit free-running up-counter. It locks onto a correctly incrementing
// sequence and counts sequence violations and counter wraps.
module count_checker #(
    parameter int LOCK_LEN = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count_in,
    input  logic       in_valid,
    input  logic       clr_err,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] wrap_count,
    output logic [3:0] expected
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LEN_C = 4'(LOCK_LEN);

    state_t     state_r, state_s;
    logic [3:0] run_r, run_s;
    logic [3:0] expected_r, expected_s;
    logic       locked_r;
    logic       err_r, err_s;
    logic [7:0] err_count_r, err_count_s;
    logic [7:0] wrap_count_r, wrap_count_s;
    logic       viol_s;
    logic       wrap_s;
    logic [3:0] run_inc_s;
    logic [3:0] count_inc_s;

    assign run_inc_s   = run_r + 4'd1;
    assign count_inc_s = count_in + 4'd1;

    // Next-state, expected value and event decode for one sample
    always_comb begin
        state_s    = state_r;
        run_s      = run_r;
        expected_s = expected_r;
        viol_s     = 1'b0;
        wrap_s     = 1'b0;
        if (in_valid) begin
            case (state_r)
                IDLE: begin
                    expected_s = count_inc_s;
                    run_s      = 4'd0;
                    state_s    = ACQ;
                end
                ACQ: begin
                    expected_s = count_inc_s;
                    if (count_in == expected_r) begin
                        run_s = run_inc_s;
                        if (run_inc_s == LOCK_LEN_C) begin
                            state_s = TRACK;
                        end else begin
                            state_s = ACQ;
                        end
                    end else begin
                        run_s   = 4'd0;
                        state_s = ACQ;
                    end
                end
                TRACK: begin
                    if (count_in == expected_r) begin
                        expected_s = count_inc_s;
                        wrap_s     = (count_in == 4'd0);
                        state_s    = TRACK;
                    end else if (count_in == 4'd0) begin
                        // A jump to zero is a legitimate restart of the source counter
                        expected_s = 4'd1;
                        run_s      = 4'd0;
                        state_s    = ACQ;
                    end else begin
                        viol_s     = 1'b1;
                        expected_s = count_inc_s;
                        run_s      = 4'd0;
                        state_s    = ACQ;
                    end
                end
                default: begin
                    expected_s = 4'd0;
                    run_s      = 4'd0;
                    state_s    = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Error flag, saturating error counter and saturating wrap counter
    always_comb begin
        err_s        = err_r;
        err_count_s  = err_count_r;
        wrap_count_s = wrap_count_r;
        if (clr_err) begin
            err_s       = viol_s;
            err_count_s = viol_s ? 8'd1 : 8'd0;
        end else if (viol_s) begin
            err_s       = 1'b1;
            err_count_s = (err_count_r == 8'd255) ? 8'd255 : err_count_r + 8'd1;
        end else begin
            err_s = err_r;
        end
        if (wrap_s && (wrap_count_r != 8'd255)) begin
            wrap_count_s = wrap_count_r + 8'd1;
        end else begin
            wrap_count_s = wrap_count_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            run_r        <= 4'd0;
            expected_r   <= 4'd0;
            locked_r     <= 1'b0;
            err_r        <= 1'b0;
            err_count_r  <= 8'd0;
            wrap_count_r <= 8'd0;
        end else begin
            state_r      <= state_s;
            run_r        <= run_s;
            expected_r   <= expected_s;
            locked_r     <= (state_s == TRACK);
            err_r        <= err_s;
            err_count_r  <= err_count_s;
            wrap_count_r <= wrap_count_s;
        end
    end

    assign locked     = locked_r;
    assign err        = err_r;
    assign err_count  = err_count_r;
    assign wrap_count = wrap_count_r;
    assign expected   = expected_r;

endmodule

// File: tb/tb_count_checker.sv
// Randomized and directed bench for count_checker against a behavioural model of
// lock acquisition, violation and wrap counting.
module tb_count_checker;

    localparam int LOCK_LEN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       in_valid = 1'b0;
    logic       clr_err = 1'b0;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [3:0] expected;

    int n_checks = 0;
    int n_errors = 0;

    // model state: has any sample been seen, lock flag, matching run, counters
    int m_started = 0;
    int m_locked  = 0;
    int m_run     = 0;
    int m_exp     = 0;
    int m_err     = 0;
    int m_errc    = 0;
    int m_wrap    = 0;

    count_checker #(.LOCK_LEN(LOCK_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .in_valid   (in_valid),
        .clr_err    (clr_err),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .expected   (expected)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_step(input int v, input int val, input int clr, input int rst);
        int viol;
        viol = 0;
        if (rst != 0) begin
            m_started = 0; m_locked = 0; m_run = 0; m_exp = 0;
            m_err = 0; m_errc = 0; m_wrap = 0;
        end else begin
            if (val != 0) begin
                if (m_started == 0) begin
                    m_started = 1;
                    m_run = 0;
                end else if (m_locked == 0) begin
                    m_run = (v == m_exp) ? m_run + 1 : 0;
                    if (m_run == LOCK_LEN) m_locked = 1;
                end else if (v == m_exp) begin
                    if (v == 0 && m_wrap < 255) m_wrap++;
                end else begin
                    m_locked = 0;
                    m_run = 0;
                    if (v != 0) viol = 1;
                end
                m_exp = (v + 1) % 16;
            end
            if (clr != 0) begin
                m_err = viol;
                m_errc = viol;
            end else if (viol != 0) begin
                m_err = 1;
                if (m_errc < 255) m_errc++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".locked"}, int'(locked), m_locked);
        check_val({tag, ".err"}, int'(err), m_err);
        check_val({tag, ".err_count"}, int'(err_count), m_errc);
        check_val({tag, ".wrap_count"}, int'(wrap_count), m_wrap);
        check_val({tag, ".expected"}, int'(expected), m_exp);
    endtask

    task automatic step(input int v, input int val, input int clr, input int rst, input string tag);
        @(negedge clk);
        count_in = 4'(v);
        in_valid = (val != 0);
        clr_err  = (clr != 0);
        reset    = (rst != 0);
        @(posedge clk);
        model_step(v, val, clr, rst);
        #1;
        compare_all(tag);
    endtask

    // relock from anywhere reachable, then a non-zero violation on the next call
    task automatic viol_cycle(input string tag);
        step(5, 1, 0, 0, tag);
        step(6, 1, 0, 0, tag);
        step(7, 1, 0, 0, tag);
    endtask

    initial begin
        int src;
        int r;
        int v;
        step(0, 0, 0, 1, "rst0");
        step(0, 1, 1, 1, "rst1");
        check_val("rst_expected", int'(expected), 0);
        check_val("rst_locked", int'(locked), 0);

        // acquisition 0,1,2
        step(0, 1, 0, 0, "acq0");
        check_val("acq0_exp", int'(expected), 1);
        check_val("acq0_lock", int'(locked), 0);
        step(1, 1, 0, 0, "acq1");
        check_val("acq1_lock", int'(locked), 0);
        step(2, 1, 0, 0, "acq2");
        check_val("acq2_lock", int'(locked), 1);
        check_val("acq2_exp", int'(expected), 3);

        // wrap while locked, with an idle cycle that must hold everything
        step(9, 0, 0, 0, "hold");
        for (int i = 3; i <= 15; i++) step(i, 1, 0, 0, "run");
        step(0, 1, 0, 0, "wrap0");
        check_val("wrap_cnt", int'(wrap_count), 1);
        step(1, 1, 0, 0, "wrap1");
        check_val("wrap_exp", int'(expected), 2);
        check_val("wrap_lock", int'(locked), 1);

        // violation 9 with expected 6, then relock
        for (int i = 2; i <= 5; i++) step(i, 1, 0, 0, "pre_viol");
        step(9, 1, 0, 0, "viol");
        check_val("viol_err", int'(err), 1);
        check_val("viol_errc", int'(err_count), 1);
        check_val("viol_exp", int'(expected), 10);
        step(10, 1, 0, 0, "relock10");
        step(11, 1, 0, 0, "relock11");
        check_val("relock_lock", int'(locked), 1);
        check_val("relock_err", int'(err), 1);

        // restart to zero with expected 6 is not an error
        step(0, 0, 1, 0, "clr");
        for (int i = 12; i <= 21; i++) step(i % 16, 1, 0, 0, "pre_rst0");
        step(0, 1, 0, 0, "restart");
        check_val("restart_err", int'(err), 0);
        check_val("restart_exp", int'(expected), 1);
        check_val("restart_lock", int'(locked), 0);
        step(1, 1, 0, 0, "restart1");
        step(2, 1, 0, 0, "restart2");
        check_val("restart_relock", int'(locked), 1);

        // clear colliding with a violation
        for (int i = 0; i < 3; i++) viol_cycle("viol3");
        check_val("errc3", int'(err_count), 3);
        step(5, 1, 1, 0, "clr_viol");
        check_val("clr_viol_err", int'(err), 1);
        check_val("clr_viol_errc", int'(err_count), 1);
        step(0, 0, 1, 0, "clr_only");
        check_val("clr_only_errc", int'(err_count), 0);

        // reach wrap_count 5, then reset with valid high
        v = 6;
        for (int i = 0; i < 200 && m_wrap < 5; i++) begin
            step(v, 1, 0, 0, "to_wrap5");
            v = (v + 1) % 16;
        end
        check_val("wrap5", int'(wrap_count), 5);
        step(v, 1, 1, 1, "mid_reset");
        check_val("mid_reset_wrap", int'(wrap_count), 0);
        check_val("mid_reset_lock", int'(locked), 0);

        // saturate err_count
        viol_cycle("sat_pre");
        for (int i = 0; i < 256; i++) viol_cycle("sat");
        check_val("errc_sat", int'(err_count), 255);
        check_val("err_sat", int'(err), 1);

        // saturate wrap_count
        v = 8;
        for (int i = 0; i < 5000 && m_wrap < 255; i++) begin
            step(v, 1, 0, 0, "wrap_sat");
            v = (v + 1) % 16;
        end
        for (int i = 0; i < 16; i++) begin
            step(v, 1, 0, 0, "wrap_sat_more");
            v = (v + 1) % 16;
        end
        check_val("wrap_sat", int'(wrap_count), 255);

        // randomized traffic
        step(0, 0, 0, 1, "rand_rst");
        src = 0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8) src = $urandom_range(0, 15);
            else if (r < 12) src = 0;
            else src = (src + 1) % 16;
            step(src, ($urandom_range(0, 9) != 0) ? 1 : 0,
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 ($urandom_range(0, 199) == 0) ? 1 : 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter LOCK_LEN, default 2, meaning: consecutive matching increments required to declare lock (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 count_in  input  4  sampled value of the monitored 4-bit free-running up-counter.
REQ-005 in_valid  input  1  count_in is sampled on a rising edge only when in_valid=1.
REQ-006 clr_err  input  1  synchronous clear of err and err_count.
REQ-007 locked  output  1  checker is tracking a correctly incrementing sequence.
REQ-008 err  output  1  sticky flag: sequence violation seen since last clear.
REQ-009 err_count  output  8  number of violations, saturating at 255.
REQ-010 wrap_count  output  8  number of accepted 15->0 wraps while locked, saturating at 255.
REQ-011 expected  output  4  value the next valid sample must equal.

Function
REQ-012 All outputs SHALL be registered; a sample taken at edge N SHALL be reflected on outputs after edge N (one-cycle latency).
REQ-013 With in_valid=0, state, expected, locked, wrap_count and err_count SHALL hold; only clr_err SHALL act.
REQ-014 The state machine SHALL have three states: IDLE, ACQ, TRACK; locked=1 exactly in TRACK.
REQ-015 expected arithmetic SHALL be modulo 16 (15+1 = 0).
REQ-016 IDLE, valid sample v: expected <= v+1, run <= 0, next state ACQ; no error possible.
REQ-017 ACQ, valid sample v == expected: expected <= v+1, run <= run+1; when run+1 == LOCK_LEN, next state TRACK.
REQ-018 ACQ, valid sample v != expected: expected <= v+1, run <= 0, stay ACQ; no error raised.
REQ-019 TRACK, v == expected: expected <= v+1; if v == 0, wrap_count increments (saturating).
REQ-020 TRACK, v != expected and v == 0: treated as legal source restart; expected <= 1, run <= 0, next state ACQ, no error.
REQ-021 TRACK, v != expected and v != 0: err <= 1, err_count increments (saturating), expected <= v+1, run <= 0, next state ACQ.
REQ-022 clr_err=1 SHALL clear err to 0 and err_count to 0 at that edge unless a violation (REQ-021) occurs in the same edge, in which case err=1 and err_count=1.
REQ-023 err_count and wrap_count at 255 SHALL remain 255 on further increments; err stays 1.
REQ-024 wrap_count SHALL never be cleared except by reset.

Reset
REQ-025 reset=1 at a rising edge SHALL force state IDLE, run=0, expected=0, locked=0, err=0, err_count=0, wrap_count=0, overriding in_valid and clr_err.
REQ-026 reset asserted mid-TRACK SHALL take effect at the next edge with no partial update; the first valid sample after reset deasserts follows REQ-016.

Verification
REQ-027 Reset, then valid samples 0,1,2 on consecutive edges -> after 0: expected=1, locked=0; after 1: locked=0; after 2: locked=1, expected=3, err=0.
REQ-028 Locked, samples 14,15,0,1 -> wrap_count=1 after 0, locked stays 1, err=0, expected=2.
REQ-029 Locked with expected=6, sample 9 -> err=1, err_count=1, locked=0, expected=10; then 10,11 -> locked=1 again, err still 1.
REQ-030 Locked with expected=6, sample 0 -> err=0, err_count unchanged, locked=0, expected=1; samples 1,2 -> locked=1.
REQ-031 err_count=3, clr_err=1 on same edge as violating sample -> err=1, err_count=1; clr_err alone next edge -> err=0, err_count=0.
REQ-032 Locked with wrap_count=5, reset pulsed one cycle with in_valid=1 -> all outputs 0 after that edge; 256 forced violations -> err_count=255.
